alu_round_sat: RTL

ALU_ROUND_SAT -- requirements
Module: alu_round_sat

---
 rtl/alu_round_sat.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_round_sat.sv
// Round-half-up arithmetic right shift then signed saturation of an ALU result, 2-stage valid/ready pipeline.
// Optional 16-bit saturation event counter enabled by macro ALU_ROUND_SAT_COUNT_EN.
`timescale 1ns/1ps
module alu_round_sat #(
    parameter int IN_W  = 55,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [5:0]       in_shift,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_sticky,
`ifdef ALU_ROUND_SAT_COUNT_EN
    output logic [15:0]      sat_count,
`endif
    output logic             sat_sticky
);

    localparam int W1 = IN_W + 1;
    localparam logic signed [W1-1:0] SAT_MAX = {{(W1-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W1-1:0] SAT_MIN = {{(W1-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    s1_vld_q, s1_vld_d;
    logic signed [W1-1:0]    s1_r_q, s1_r_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic                    sticky_q, sticky_d;

    logic                    adv;
    logic [4:0]              shamt;
    logic signed [W1-1:0]    ext, addend, rnd_sum, rnd_res;
    logic                    sat_hit;
    logic [OUT_W-1:0]        sat_dat;
    logic                    load_sat;

    // Whole pipeline moves together; it only stalls when the output is held.
    assign adv      = !s2_vld_q || out_ready;
    assign in_ready = adv;

    assign shamt = (in_shift > 6'd31) ? 5'd31 : in_shift[4:0];

    // One extra bit of headroom keeps the rounding addend from wrapping.
    always_comb begin
        ext     = {in_data[IN_W-1], in_data};
        addend  = '0;
        if (shamt != 5'd0)
            addend = W1'(1) << (shamt - 5'd1);
        rnd_sum = ext + addend;
        rnd_res = rnd_sum >>> shamt;
    end

    always_comb begin
        sat_hit = 1'b0;
        sat_dat = s1_r_q[OUT_W-1:0];
        if (s1_r_q > SAT_MAX) begin
            sat_hit = 1'b1;
            sat_dat = SAT_MAX[OUT_W-1:0];
        end else if (s1_r_q < SAT_MIN) begin
            sat_hit = 1'b1;
            sat_dat = SAT_MIN[OUT_W-1:0];
        end
    end

    assign load_sat = adv && s1_vld_q && sat_hit;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_r_d     = s1_r_q;
        s2_vld_d   = s2_vld_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (adv) begin
            s1_vld_d = in_valid;
            if (in_valid)
                s1_r_d = rnd_res;
            s2_vld_d = s1_vld_q;
            // A bubble leaves the previous output word in place.
            if (s1_vld_q) begin
                out_data_d = sat_dat;
                out_sat_d  = sat_hit;
            end
        end
        if (load_sat)
            sticky_d = 1'b1;
        else if (clr_sticky)
            sticky_d = 1'b0;
        else
            sticky_d = sticky_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_r_q     <= '0;
            s2_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_r_q     <= s1_r_d;
            s2_vld_q   <= s2_vld_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sticky_q;

`ifdef ALU_ROUND_SAT_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // A clear coinciding with an event restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_sat) begin
            if (clr_sticky)
                cnt_d = 16'd1;
            else if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end else if (clr_sticky) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

    assign sat_count = cnt_q;
`endif

endmodule
